// File: rtl/anton_neopixel_rx_decoder.sv
// WS2812 loopback decoder: recovers MSB-first bytes from 8-tick pulse-width bits, frames split by the reset gap.
// Optional stats counters: define ANTON_NEOPIXEL_RX_STATS_EN. rxValid 3 cycles after the pin falls; no back-pressure.
`ifndef RESET_DELAY_DEFAULT
`define RESET_DELAY_DEFAULT 320
`endif

module anton_neopixel_rx_decoder #(
    parameter int unsigned RESET_DELAY = `RESET_DELAY_DEFAULT,
    parameter int unsigned BIT_MIN     = 1,
    parameter int unsigned BIT1_MIN    = 4,
    parameter int unsigned BIT_MAX     = 7
) (
    input  logic        clk6_4mhz,
    input  logic        apbPresern,
    input  logic        neoData,
    output logic [7:0]  rxData,
    output logic        rxValid,
    output logic [15:0] rxIndex,
    output logic        frameDone,
    output logic [15:0] frameBytes,
    output logic        rxError,
    output logic        armed,
    output logic [15:0] frameCount,
    output logic [15:0] errorCount
);

    localparam int CW = $clog2(RESET_DELAY + 1);
    localparam logic [CW-1:0] RD_C   = CW'(RESET_DELAY);
    localparam logic [CW-1:0] HMIN_C = CW'(BIT_MIN);
    localparam logic [CW-1:0] H1_C   = CW'(BIT1_MIN);
    localparam logic [CW-1:0] HMAX_C = CW'(BIT_MAX);

    typedef enum logic [1:0] {SYNC_WAIT, IDLE, HIGH, LOW} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [CW-1:0] low_cnt_q, low_cnt_d;
    logic [CW-1:0] high_cnt_q, high_cnt_d;
    logic [CW-1:0] low_inc, high_inc;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [15:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic [15:0]   rx_index_q, rx_index_d;
    logic          frame_done_q, frame_done_d;
    logic [15:0]   frame_bytes_q, frame_bytes_d;
    logic          rx_error_q, rx_error_d;
    logic          armed_q, armed_d;
    logic          new_bit;

    assign low_inc  = (low_cnt_q  == '1) ? low_cnt_q  : low_cnt_q  + CW'(1);
    assign high_inc = (high_cnt_q == '1) ? high_cnt_q : high_cnt_q + CW'(1);

    always_ff @(posedge clk6_4mhz or negedge apbPresern) begin
        if (!apbPresern) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            state_q       <= SYNC_WAIT;
            low_cnt_q     <= '0;
            high_cnt_q    <= '0;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'd0;
            byte_cnt_q    <= 16'd0;
            rx_data_q     <= 8'd0;
            rx_valid_q    <= 1'b0;
            rx_index_q    <= 16'd0;
            frame_done_q  <= 1'b0;
            frame_bytes_q <= 16'd0;
            rx_error_q    <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            sync1_q       <= neoData;
            sync2_q       <= sync1_q;
            state_q       <= state_d;
            low_cnt_q     <= low_cnt_d;
            high_cnt_q    <= high_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            byte_cnt_q    <= byte_cnt_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_index_q    <= rx_index_d;
            frame_done_q  <= frame_done_d;
            frame_bytes_q <= frame_bytes_d;
            rx_error_q    <= rx_error_d;
            armed_q       <= armed_d;
        end
    end

    // The FSM tracks the line level, so a synchronised edge is simply a level that disagrees with the state.
    always_comb begin
        state_d       = state_q;
        low_cnt_d     = low_cnt_q;
        high_cnt_d    = high_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        byte_cnt_d    = byte_cnt_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_index_d    = rx_index_q;
        frame_done_d  = 1'b0;
        frame_bytes_d = frame_bytes_q;
        rx_error_d    = 1'b0;
        armed_d       = armed_q;
        new_bit       = 1'b0;
        case (state_q)
            SYNC_WAIT: begin
                if (sync2_q) begin
                    low_cnt_d = '0;
                end else if (low_inc == RD_C) begin
                    state_d   = IDLE;
                    armed_d   = 1'b1;
                    low_cnt_d = '0;
                end else begin
                    low_cnt_d = low_inc;
                end
            end
            IDLE: begin
                if (sync2_q) begin
                    state_d    = HIGH;
                    high_cnt_d = CW'(1);
                end
            end
            HIGH: begin
                if (sync2_q ? (high_cnt_q >= HMAX_C) : (high_cnt_q < HMIN_C)) begin
                    // Bad pulse width: drop the frame and resynchronise on a full reset gap.
                    rx_error_d = 1'b1;
                    armed_d    = 1'b0;
                    state_d    = SYNC_WAIT;
                    low_cnt_d  = '0;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 16'd0;
                    shift_d    = 8'd0;
                end else if (sync2_q) begin
                    high_cnt_d = high_inc;
                end else begin
                    new_bit   = (high_cnt_q >= H1_C);
                    shift_d   = {shift_q[6:0], new_bit};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    low_cnt_d = CW'(1);
                    state_d   = LOW;
                    if (bit_cnt_q == 3'd7) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = {shift_q[6:0], new_bit};
                        rx_index_d = byte_cnt_q;
                        byte_cnt_d = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
                    end
                end
            end
            LOW: begin
                if (sync2_q) begin
                    state_d    = HIGH;
                    high_cnt_d = CW'(1);
                end else if (low_inc == RD_C) begin
                    if (bit_cnt_q == 3'd0) begin
                        frame_done_d  = 1'b1;
                        frame_bytes_d = byte_cnt_q;
                    end else begin
                        rx_error_d = 1'b1;
                    end
                    byte_cnt_d = 16'd0;
                    bit_cnt_d  = 3'd0;
                    low_cnt_d  = '0;
                    state_d    = IDLE;
                end else begin
                    low_cnt_d = low_inc;
                end
            end
            default: state_d = SYNC_WAIT;
        endcase
    end

    assign rxData     = rx_data_q;
    assign rxValid    = rx_valid_q;
    assign rxIndex    = rx_index_q;
    assign frameDone  = frame_done_q;
    assign frameBytes = frame_bytes_q;
    assign rxError    = rx_error_q;
    assign armed      = armed_q;

`ifdef ANTON_NEOPIXEL_RX_STATS_EN
    logic [15:0] frame_count_q, error_count_q;

    // Counters advance on the same edge as the strobe, so they read updated while the strobe is high.
    always_ff @(posedge clk6_4mhz or negedge apbPresern) begin
        if (!apbPresern) begin
            frame_count_q <= 16'd0;
            error_count_q <= 16'd0;
        end else begin
            if (frame_done_d && frame_count_q != 16'hFFFF)
                frame_count_q <= frame_count_q + 16'd1;
            if (rx_error_d && error_count_q != 16'hFFFF)
                error_count_q <= error_count_q + 16'd1;
        end
    end

    assign frameCount = frame_count_q;
    assign errorCount = error_count_q;
`else
    assign frameCount = 16'd0;
    assign errorCount = 16'd0;
`endif

endmodule

// File: tb/tb_anton_neopixel_rx_decoder.sv
// Bench for anton_neopixel_rx_decoder: directed pulse trains, expected strobes queued and checked by a monitor.
`timescale 1ns/1ps

module tb_anton_neopixel_rx_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        neo;
    logic [7:0]  rxData;
    logic        rxValid;
    logic [15:0] rxIndex;
    logic        frameDone;
    logic [15:0] frameBytes;
    logic        rxError;
    logic        armed;
    logic [15:0] frameCount;
    logic [15:0] errorCount;

    int n_cmp = 0;
    int n_err = 0;
    int exp_fc = 0;
    int exp_ec = 0;

    logic [23:0] byte_q[$];   // {index, data}
    logic [31:0] frame_q[$];  // {frameBytes, frameCount}
    logic [16:0] err_q[$];    // {armed, errorCount}

    anton_neopixel_rx_decoder #(.RESET_DELAY(64)) dut (
        .clk6_4mhz (clk),
        .apbPresern(rst_n),
        .neoData   (neo),
        .rxData    (rxData),
        .rxValid   (rxValid),
        .rxIndex   (rxIndex),
        .frameDone (frameDone),
        .frameBytes(frameBytes),
        .rxError   (rxError),
        .armed     (armed),
        .frameCount(frameCount),
        .errorCount(errorCount)
    );

    always #5 clk = ~clk;

    function automatic int stat(input int v);
`ifdef ANTON_NEOPIXEL_RX_STATS_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: strobe with nothing expected (t=%0t)", name, $time);
    endtask

    // Monitor: pops an expectation for every strobe the DUT presents.
    initial begin
        logic [23:0] b;
        logic [31:0] f;
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (rxValid) begin
                if (byte_q.size() == 0) unexpected("rxValid");
                else begin
                    b = byte_q.pop_front();
                    chk("rxData", int'(rxData), int'(b[7:0]));
                    chk("rxIndex", int'(rxIndex), int'(b[23:8]));
                end
            end
            if (frameDone) begin
                if (frame_q.size() == 0) unexpected("frameDone");
                else begin
                    f = frame_q.pop_front();
                    chk("frameBytes", int'(frameBytes), int'(f[31:16]));
                    chk("frameCount", int'(frameCount), int'(f[15:0]));
                end
            end
            if (rxError) begin
                if (err_q.size() == 0) unexpected("rxError");
                else begin
                    e = err_q.pop_front();
                    chk("errorCount", int'(errorCount), int'(e[15:0]));
                    chk("armed_at_error", int'(armed), int'(e[16]));
                end
            end
        end
    end

    task automatic exp_byte(input logic [7:0] d, input logic [15:0] idx);
        byte_q.push_back({idx, d});
    endtask

    task automatic exp_frame(input logic [15:0] nb);
        exp_fc++;
        frame_q.push_back({nb, 16'(stat(exp_fc))});
    endtask

    task automatic exp_err(input logic arm);
        exp_ec++;
        err_q.push_back({arm, 16'(stat(exp_ec))});
    endtask

    task automatic send_bit(input int h);
        neo = 1'b1;
        repeat (h) @(negedge clk);
        neo = 1'b0;
        repeat (8 - h) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i] ? 5 : 2);
    endtask

    task automatic gap(input int n);
        neo = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rxData"}, int'(rxData), 0);
        chk({tag, "_rxValid"}, int'(rxValid), 0);
        chk({tag, "_rxIndex"}, int'(rxIndex), 0);
        chk({tag, "_frameDone"}, int'(frameDone), 0);
        chk({tag, "_frameBytes"}, int'(frameBytes), 0);
        chk({tag, "_rxError"}, int'(rxError), 0);
        chk({tag, "_armed"}, int'(armed), 0);
        chk({tag, "_frameCount"}, int'(frameCount), 0);
        chk({tag, "_errorCount"}, int'(errorCount), 0);
    endtask

    task automatic reset_and_arm();
        @(negedge clk);
        rst_n = 1'b0;
        neo   = 1'b0;
        exp_fc = 0;
        exp_ec = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gap(70);
        chk("rearm_armed", int'(armed), 1);
    endtask

    initial begin
        int w[8];
        rst_n = 1'b0;
        neo   = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // 1: arming gap
        gap(10);
        chk("armed_early", int'(armed), 0);
        gap(60);
        chk("armed_after_gap", int'(armed), 1);

        // 2: single byte frame
        exp_byte(8'hA5, 16'd0);
        exp_frame(16'd1);
        send_byte(8'hA5);
        gap(70);

        // 3: three byte frame with fresh counters
        reset_and_arm();
        exp_byte(8'h00, 16'd0);
        exp_byte(8'hFF, 16'd1);
        exp_byte(8'h3C, 16'd2);
        exp_frame(16'd3);
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h3C);
        gap(70);

        // Width boundaries: 7 and 4 decode as 1, 1 and 3 as 0 -> 0xAA
        w = '{7, 1, 4, 3, 7, 1, 4, 3};
        exp_byte(8'hAA, 16'd0);
        exp_frame(16'd1);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
        gap(70);

        // 4: overlong pulse mid-byte, following byte ignored until re-armed
        exp_err(1'b0);
        send_bit(5); send_bit(2); send_bit(5); send_bit(5);
        neo = 1'b1;
        repeat (9) @(negedge clk);
        neo = 1'b0;
        send_byte(8'h55);
        chk("armed_after_error", int'(armed), 0);
        gap(70);
        chk("rearmed_after_error", int'(armed), 1);

        // 5: 12 bits then gap -> one byte, then error, no frameDone
        exp_byte(8'h96, 16'd0);
        exp_err(1'b1);
        send_byte(8'h96);
        send_bit(5); send_bit(2); send_bit(5); send_bit(2);
        gap(70);
        chk("armed_after_partial", int'(armed), 1);
        exp_byte(8'h11, 16'd0);
        exp_frame(16'd1);
        send_byte(8'h11);
        gap(70);

        // 6: reset in the middle of byte 2
        exp_byte(8'h12, 16'd0);
        send_byte(8'h12);
        send_bit(5); send_bit(5); send_bit(2);
        neo = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        neo   = 1'b0;
        #1;
        check_zero("midframe_reset");
        exp_fc = 0;
        exp_ec = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        gap(30);
        chk("armed_post_reset_early", int'(armed), 0);
        gap(40);
        chk("armed_post_reset", int'(armed), 1);
        exp_byte(8'h5A, 16'd0);
        exp_frame(16'd1);
        send_byte(8'h5A);
        gap(70);

        repeat (5) @(negedge clk);
        chk("bytes_outstanding", byte_q.size(), 0);
        chk("frames_outstanding", frame_q.size(), 0);
        chk("errors_outstanding", err_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
